fetch_ctrl: RTL and testbench



---
 rtl/arm_core_pkg.sv | 26 ++
 rtl/hw_queue.sv | 76 +++++++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_core_pkg.sv
// Shared core definitions: Thumb-2 32-bit length-decode prefixes and the
// instruction fetch FSM encoding.
package arm_core_pkg;

   localparam logic [4:0] T32_PFX_0 = 5'b11101;
   localparam logic [4:0] T32_PFX_1 = 5'b11110;
   localparam logic [4:0] T32_PFX_2 = 5'b11111;

   localparam logic [1:0] FS_IDLE    = 2'd0;
   localparam logic [1:0] FS_WAIT    = 2'd1;
   localparam logic [1:0] FS_DISCARD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = FS_IDLE,
      ST_WAIT    = FS_WAIT,
      ST_DISCARD = FS_DISCARD
   } fetch_state_e;

   // A halfword starts a 32-bit Thumb-2 encoding when its top five bits match a prefix.
   function automatic logic is_t32(input logic [15:0] hw);
      logic [4:0] pfx;
      pfx = hw[15:11];
      return (pfx == T32_PFX_0) || (pfx == T32_PFX_1) || (pfx == T32_PFX_2);
   endfunction

endpackage

// File: rtl/hw_queue.sv
// Circular halfword prefetch FIFO: push one, pop one or two, synchronous clear,
// with read ports for the head and the entry behind it.
module hw_queue
   import arm_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      push,
   input  logic [15:0]               push_data,
   input  logic                      pop1,
   input  logic                      pop2,
   output logic [$clog2(DEPTH):0]    count,
   output logic [15:0]               head,
   output logic [15:0]               head_next
);

   localparam int PW = $clog2(DEPTH);

   logic [15:0]   mem_r [DEPTH];
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_nxt_s;
   logic [PW:0]   count_r;
   logic [PW:0]   pop_n_s;

   // Number of halfwords leaving the head this cycle.
   always_comb begin
      pop_n_s = {(PW+1){1'b0}};
      if (pop2) begin
         pop_n_s = (PW+1)'(2'd2);
      end else if (pop1) begin
         pop_n_s = (PW+1)'(1'b1);
      end else begin
         pop_n_s = {(PW+1){1'b0}};
      end
   end

   // Pointer and occupancy update; clear wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else if (clr) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         rd_ptr_r <= rd_ptr_r + pop_n_s[PW-1:0];
         count_r  <= count_r + {{PW{1'b0}}, push} - pop_n_s;
      end
   end

   // Storage write at the tail.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (push && !clr) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign rd_nxt_s  = rd_ptr_r + PW'(1'b1);
   assign head      = mem_r[rd_ptr_r];
   assign head_next = mem_r[rd_nxt_s];
   assign count     = count_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences halfword fetches into a prefetch queue,
// assembles 16/32-bit Thumb-2 instructions for pre-decode and handles redirects.
module fetch_ctrl
   import arm_core_pkg::*;
#(
   parameter int            AW         = 21,
   parameter int            QDEPTH     = 4,
   parameter logic [AW-1:0] RESET_ADDR = {AW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic [15:0]   imem_rdata,
   input  logic          branch_valid,
   input  logic [AW-1:0] branch_target,
   output logic          inst_valid,
   output logic [31:0]   inst,
   output logic          inst_is32,
   output logic [AW-1:0] inst_pc,
   input  logic          inst_ready
);

   localparam int CW = $clog2(QDEPTH);

   fetch_state_e  state_r;
   logic [AW-1:0] fetch_addr_r;
   logic [AW-1:0] head_pc_r;
   logic [CW:0]   count_s;
   logic [CW:0]   inflight_s;
   logic [15:0]   hw0_s;
   logic [15:0]   hw1_s;
   logic          is32_s;
   logic          req_s;
   logic          gnt_s;
   logic          push_s;
   logic          valid_s;
   logic          pop1_s;
   logic          pop2_s;

   hw_queue #(
      .DEPTH     (QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (branch_valid),
      .push      (push_s),
      .push_data (imem_rdata),
      .pop1      (pop1_s),
      .pop2      (pop2_s),
      .count     (count_s),
      .head      (hw0_s),
      .head_next (hw1_s)
   );

   // Request issue: the in-flight halfword already owns a queue slot; reset gates it low.
   always_comb begin
      inflight_s = count_s + {{CW{1'b0}}, (state_r == ST_WAIT)};
      if (!rst_n || branch_valid || (state_r == ST_DISCARD)) begin
         req_s = 1'b0;
      end else begin
         req_s = (inflight_s < (CW+1)'(QDEPTH));
      end
      gnt_s  = req_s && imem_gnt;
      push_s = (state_r == ST_WAIT) && !branch_valid;
   end

   // Length decode and pre-decode handshake from the queue head.
   always_comb begin
      is32_s = is_t32(hw0_s);
      if (branch_valid) begin
         valid_s = 1'b0;
      end else if (is32_s) begin
         valid_s = (count_s >= (CW+1)'(2'd2));
      end else begin
         valid_s = (count_s >= (CW+1)'(1'b1));
      end
      pop2_s = valid_s && inst_ready && is32_s;
      pop1_s = valid_s && inst_ready && !is32_s;
      if (is32_s) begin
         inst = {hw0_s, hw1_s};
      end else begin
         inst = {hw0_s, 16'h0000};
      end
   end

   // Fetch FSM with fetch and head address counters; a redirect overrides everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         fetch_addr_r <= RESET_ADDR;
         head_pc_r    <= RESET_ADDR;
      end else if (branch_valid) begin
         fetch_addr_r <= branch_target;
         head_pc_r    <= branch_target;
         if (state_r == ST_IDLE) begin
            state_r <= ST_IDLE;
         end else begin
            state_r <= ST_DISCARD;
         end
      end else begin
         if (gnt_s) begin
            fetch_addr_r <= fetch_addr_r + AW'(1'b1);
         end
         if (pop2_s) begin
            head_pc_r <= head_pc_r + AW'(2'd2);
         end else if (pop1_s) begin
            head_pc_r <= head_pc_r + AW'(1'b1);
         end
         case (state_r)
            ST_IDLE:    state_r <= gnt_s ? ST_WAIT : ST_IDLE;
            ST_WAIT:    state_r <= gnt_s ? ST_WAIT : ST_IDLE;
            ST_DISCARD: state_r <= ST_IDLE;
            default:    state_r <= ST_IDLE;
         endcase
      end
   end

   assign imem_req   = req_s;
   assign imem_addr  = fetch_addr_r;
   assign inst_valid = valid_s;
   assign inst_is32  = is32_s;
   assign inst_pc    = head_pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: a registered halfword memory model
// answers grants, expected instructions are queued and checked on acceptance.
module tb_fetch_ctrl;

   localparam int AW = 21;

   typedef struct packed {
      logic [31:0]   inst;
      logic          is32;
      logic [AW-1:0] pc;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic [15:0]   imem_rdata;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          inst_valid;
   logic [31:0]   inst;
   logic          inst_is32;
   logic [AW-1:0] inst_pc;
   logic          inst_ready;

   logic [15:0] mem [int unsigned];
   exp_t        sb [$];
   int          tests;
   int          fails;
   int          grants;
   int          g0;

   fetch_ctrl #(.AW(AW), .QDEPTH(4), .RESET_ADDR({AW{1'b0}})) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rdata    (imem_rdata),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_is32     (inst_is32),
      .inst_pc       (inst_pc),
      .inst_ready    (inst_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(32'(a))) return mem[32'(a)];
      return 16'hBF00;
   endfunction

   // Memory answers one cycle after each request/grant; otherwise returns junk.
   always @(posedge clk) begin
      if (imem_req && imem_gnt) imem_rdata <= mem_rd(imem_addr);
      else imem_rdata <= 16'hDEAD;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] i, input logic s, input logic [AW-1:0] p);
      exp_t e;
      e.inst = i;
      e.is32 = s;
      e.pc   = p;
      sb.push_back(e);
   endtask

   // One clock: observe at the falling edge, return just after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (rst_n && imem_req && imem_gnt) grants++;
      if (rst_n && inst_valid && inst_ready) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_inst: observed pc=%h inst=%h expected none", inst_pc, inst);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("inst", inst, e.inst);
            chk("inst_is32", 32'(inst_is32), 32'(e.is32));
            chk("inst_pc", 32'(inst_pc), 32'(e.pc));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         tick();
      end
      chk(tag, 32'(sb.size()), 32'd0);
      inst_ready = 1'b0;
   endtask

   task automatic do_branch(input logic [AW-1:0] t);
      branch_target = t;
      branch_valid  = 1'b1;
      tick();
      branch_valid  = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0; grants = 0;
      rst_n = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
      branch_valid = 1'b0; branch_target = {AW{1'b0}};
      mem[0] = 16'h2001; mem[1] = 16'hBF08; mem[2] = 16'hF04F; mem[3] = 16'h0000;
      for (int a = 32'h40; a < 32'h44; a++) mem[a] = 16'h0000;
      mem[32'h40] = 16'hF000; mem[32'h41] = 16'hF800; mem[32'h42] = 16'h4770; mem[32'h43] = 16'hE7FE;
      for (int a = 32'h80; a < 32'h90; a++) mem[a] = 16'h1111;
      mem[32'h100] = 16'h2101; mem[32'h101] = 16'hF7FF; mem[32'h102] = 16'hFFFE; mem[32'h103] = 16'h3101;
      mem[32'h200] = 16'hF8D0; mem[32'h201] = 16'h1004; mem[32'h202] = 16'h2202;
      mem[32'h1FFFFE] = 16'h2005; mem[32'h1FFFFF] = 16'hF3AF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'h0000_0000);
      chk("rst_is32", 32'(inst_is32), 32'd0);
      chk("rst_pc", 32'(inst_pc), 32'd0);

      // Basic stream after reset: 16, 16, 32-bit.
      push_exp(32'h2001_0000, 1'b0, 21'h0);
      push_exp(32'hBF08_0000, 1'b0, 21'h1);
      push_exp(32'hF04F_0000, 1'b1, 21'h2);
      rst_n = 1'b1; inst_ready = 1'b1;
      #1;
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", 32'(imem_addr), 32'd0);
      wait_drain("drain_basic");

      // Back-pressure: queue fills to exactly QDEPTH halfwords.
      do_branch(21'h40);
      g0 = grants;
      repeat (10) tick();
      chk("full_grants", 32'(grants - g0), 32'd4);
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_addr", 32'(imem_addr), 32'h44);
      chk("full_valid", 32'(inst_valid), 32'd1);
      push_exp(32'hF000_F800, 1'b1, 21'h40);
      push_exp(32'h4770_0000, 1'b0, 21'h42);
      push_exp(32'hE7FE_0000, 1'b0, 21'h43);
      push_exp(32'hBF00_0000, 1'b0, 21'h44);
      inst_ready = 1'b1;
      wait_drain("drain_full");

      // Redirect while a fetch is in flight.
      do_branch(21'h80);
      for (int i = 0; i < 20; i++) begin
         if (imem_req && imem_gnt) break;
         tick();
      end
      tick();
      branch_target = 21'h100; branch_valid = 1'b1;
      #1;
      chk("br_req", 32'(imem_req), 32'd0);
      chk("br_valid", 32'(inst_valid), 32'd0);
      tick();
      branch_valid = 1'b0;
      #1;
      chk("discard_req", 32'(imem_req), 32'd0);
      tick();
      chk("br_req_after", 32'(imem_req), 32'd1);
      chk("br_addr_after", 32'(imem_addr), 32'h100);
      push_exp(32'h2101_0000, 1'b0, 21'h100);
      push_exp(32'hF7FF_FFFE, 1'b1, 21'h101);
      push_exp(32'h3101_0000, 1'b0, 21'h103);
      inst_ready = 1'b1;
      wait_drain("drain_branch");

      // Grant stall splitting a 32-bit instruction.
      push_exp(32'hF8D0_1004, 1'b1, 21'h200);
      push_exp(32'h2202_0000, 1'b0, 21'h202);
      inst_ready = 1'b1;
      do_branch(21'h200);
      for (int i = 0; i < 20; i++) begin
         if (imem_req && imem_addr == 21'h200) break;
         tick();
      end
      tick();
      imem_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_req", 32'(imem_req), 32'd1);
         chk("stall_addr", 32'(imem_addr), 32'h201);
         chk("stall_valid", 32'(inst_valid), 32'd0);
         tick();
      end
      imem_gnt = 1'b1;
      wait_drain("drain_stall");

      // Address wrap with a 32-bit instruction straddling the top of memory.
      mem[0] = 16'h8000;
      do_branch(21'h1FFFFE);
      push_exp(32'h2005_0000, 1'b0, 21'h1FFFFE);
      push_exp(32'hF3AF_8000, 1'b1, 21'h1FFFFF);
      push_exp(32'hBF08_0000, 1'b0, 21'h1);
      inst_ready = 1'b1;
      wait_drain("drain_wrap");

      // Reset in WAIT with three halfwords queued.
      do_branch(21'h300);
      g0 = grants;
      for (int i = 0; i < 20; i++) begin
         if (grants - g0 >= 4) break;
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_valid", 32'(inst_valid), 32'd0);
      chk("mid_rst_inst", inst, 32'h0000_0000);
      chk("mid_rst_pc", 32'(inst_pc), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rel_req", 32'(imem_req), 32'd1);
      chk("rel_addr", 32'(imem_addr), 32'd0);
      push_exp(32'h8000_0000, 1'b0, 21'h0);
      push_exp(32'hBF08_0000, 1'b0, 21'h1);
      push_exp(32'hF04F_0000, 1'b1, 21'h2);
      inst_ready = 1'b1;
      wait_drain("drain_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
